// File: rtl/adder_seq_multiword_if.sv
// Request/response bundle for adder_seq_multiword: val/rdy request carrying operands,
// val/rdy response carrying the registered result. Optional `sub` under ADDER_SEQ_SUB_EN.
interface adder_seq_multiword_if #(
    parameter int unsigned W = 16
) ();
    logic         req_val;
    logic         req_rdy;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         cin;
`ifdef ADDER_SEQ_SUB_EN
    logic         sub;
`endif
    logic         resp_val;
    logic         resp_rdy;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output req_val,
        output in0,
        output in1,
        output cin,
`ifdef ADDER_SEQ_SUB_EN
        output sub,
`endif
        output resp_rdy,
        input  req_rdy,
        input  resp_val,
        input  sum,
        input  cout
    );

    modport slave (
        input  req_val,
        input  in0,
        input  in1,
        input  cin,
`ifdef ADDER_SEQ_SUB_EN
        input  sub,
`endif
        input  resp_rdy,
        output req_rdy,
        output resp_val,
        output sum,
        output cout
    );
endinterface

// File: rtl/adder_seq_multiword.sv
// Wide adder built from one 4-bit ripple-carry slice reused over NSLICES cycles, LS nibble first.
// Define ADDER_SEQ_SUB_EN to add a `sub` request field (in0 - in1 via ~in1 and carry-in of 1).
module adder_seq_multiword #(
    parameter int unsigned NSLICES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    adder_seq_multiword_if.slave bus
);
    localparam int unsigned W  = 4 * NSLICES;
    localparam int unsigned CW = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    localparam logic [CW-1:0] LastCnt = CW'(NSLICES - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_cout;

    logic          w_accept;
    logic          w_last;
    logic [W-1:0]  w_b_in;
    logic          w_cin_in;
    logic [3:0]    w_a_nib;
    logic [3:0]    w_b_nib;
    logic [3:0]    w_slice_sum;
    logic [4:0]    w_c;

    assign w_accept = (r_state == S_IDLE) && bus.req_val;
    assign w_last   = (r_cnt == LastCnt);

`ifdef ADDER_SEQ_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of 1, overriding cin.
    assign w_b_in   = bus.sub ? ~bus.in1 : bus.in1;
    assign w_cin_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_in   = bus.in1;
    assign w_cin_in = bus.cin;
`endif

    // Single 4-bit ripple-carry slice selected by the nibble counter.
    assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4];
    assign w_c[0]  = r_carry;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign w_slice_sum[i] = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
        assign w_c[i+1]       = (w_a_nib[i] & w_b_nib[i]) | (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  if (bus.resp_rdy) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.in0;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_CALC: begin
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_slice_sum;
                    r_carry                    <= w_c[4];
                    // Counter parks on the last slice rather than wrapping.
                    if (w_last) begin
                        r_cout <= w_c[4];
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_rdy  = (r_state == S_IDLE);
    assign bus.resp_val = (r_state == S_DONE);
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
endmodule
